// File: rtl/decimal_display.sv
// 8-digit multiplexed common-anode 7-segment driver with INT/FRAC pages and per-frame snapshots.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros of the integer part on the INT page.
module decimal_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sign,
    input  logic [23:0] int_val_6,
    input  logic [23:0] frac_val_6,
    input  logic        page_btn,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        page
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b0000110;
        endcase
        return g;
    endfunction

    logic [DW-1:0] div_r;
    logic [2:0]    idx_r;
    logic [3:0]    snap_sign_r;
    logic [23:0]   snap_int_r;
    logic [23:0]   snap_frac_r;
    logic          page_r;
    logic          page_next_r;
    logic          sync1_r, sync2_r, btn_prev_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic [7:0]    an_r;

    logic          tick_s;
    logic          frame_s;
    logic          btn_rise_s;
    logic [2:0]    int_pos_s;
    logic [6:0]    glyph_s;
    logic          dp_s;
    logic [7:0]    an_s;
`ifdef LEADING_ZERO_BLANK_EN
    logic [5:0]    lz_s;
`endif

    // Scan timing and button edge strobes
    always_comb begin
        tick_s     = (div_r == DIV_LAST);
        frame_s    = tick_s && (idx_r == 3'd7);
        btn_rise_s = sync2_r && !btn_prev_r;
        int_pos_s  = idx_r - 3'd1;
        an_s       = ~(8'h01 << idx_r);
    end

`ifdef LEADING_ZERO_BLANK_EN
    // lz_s[k]: integer nibbles k..5 are all zero
    always_comb begin
        lz_s    = 6'b000000;
        lz_s[5] = (snap_int_r[23:20] == 4'h0);
        for (int k = 4; k >= 0; k--) begin
            lz_s[k] = lz_s[k + 1] && (snap_int_r[4*k +: 4] == 4'h0);
        end
    end
`endif

    // Glyph and decimal point for the digit currently indexed
    always_comb begin
        glyph_s = GLYPH_BLANK;
        dp_s    = 1'b1;
        if (!page_r) begin
            case (idx_r)
                3'd7: glyph_s = (snap_sign_r != 4'h0) ? GLYPH_MINUS : GLYPH_BLANK;
                3'd0: glyph_s = bcd_glyph(snap_frac_r[23:20]);
                default: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if ((idx_r >= 3'd2) && lz_s[int_pos_s]) begin
                        glyph_s = GLYPH_BLANK;
                    end else begin
                        glyph_s = bcd_glyph(snap_int_r[{int_pos_s, 2'b00} +: 4]);
                    end
`else
                    glyph_s = bcd_glyph(snap_int_r[{int_pos_s, 2'b00} +: 4]);
`endif
                    dp_s = (idx_r != 3'd1);
                end
            endcase
        end else begin
            case (idx_r)
                3'd7, 3'd6: glyph_s = GLYPH_BLANK;
                default:    glyph_s = bcd_glyph(snap_frac_r[{idx_r, 2'b00} +: 4]);
            endcase
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
            idx_r <= 3'd0;
        end else if (tick_s) begin
            div_r <= '0;
            idx_r <= idx_r + 3'd1;
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    // Frame snapshot and page register; only updated on frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_sign_r <= 4'h0;
            snap_int_r  <= 24'h000000;
            snap_frac_r <= 24'h000000;
            page_r      <= 1'b0;
        end else if (frame_s) begin
            snap_sign_r <= sign;
            snap_int_r  <= int_val_6;
            snap_frac_r <= frac_val_6;
            page_r      <= page_next_r;
        end
    end

    // Button synchronizer, edge detect and pending page toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            btn_prev_r  <= 1'b0;
            page_next_r <= 1'b0;
        end else begin
            sync1_r    <= page_btn;
            sync2_r    <= sync1_r;
            btn_prev_r <= sync2_r;
            if (btn_rise_s) begin
                page_next_r <= !page_next_r;
            end
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
            an_r  <= 8'hFF;
        end else begin
            seg_r <= glyph_s;
            dp_r  <= dp_s;
            an_r  <= an_s;
        end
    end

    assign seg  = seg_r;
    assign dp   = dp_r;
    assign an   = an_r;
    assign page = page_r;
endmodule

// File: tb/tb_decimal_display.sv
// Self-checking bench for decimal_display (SCAN_DIV=4) with a cycle-indexed reference model.
module tb_decimal_display;
    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  sign = 4'h0;
    logic [23:0] int_val_6 = 24'h0;
    logic [23:0] frac_val_6 = 24'h0;
    logic        page_btn = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        page;

    decimal_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .sign(sign), .int_val_6(int_val_6),
        .frac_val_6(frac_val_6), .page_btn(page_btn),
        .seg(seg), .dp(dp), .an(an), .page(page)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          n = 0;
    logic [3:0]  m_sign;
    logic [23:0] m_int, m_frac;
    logic        m_page, m_page_next;
    logic        s1, s2, s3;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_page;
    logic [7:0]  exp_an;
    logic [6:0]  pat [10];

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
    end

    function automatic logic [6:0] dig(input int v);
        return (v < 10) ? pat[v] : 7'b0000110;
    endfunction

    function automatic logic [6:0] ref_glyph(input int d);
        int above;
        if (!m_page) begin
            if (d == 7) return (m_sign != 4'h0) ? 7'b0111111 : 7'b1111111;
            if (d == 0) return dig(int'(m_frac >> 20));
            above = int'(m_int >> (4 * (d - 1)));
`ifdef LEADING_ZERO_BLANK_EN
            if (d >= 2 && above == 0) return 7'b1111111;
`endif
            return dig(above % 16);
        end
        if (d >= 6) return 7'b1111111;
        return dig(int'(m_frac >> (4 * d)) % 16);
    endfunction

    task automatic model_reset();
        n = 0; m_sign = 4'h0; m_int = 24'h0; m_frac = 24'h0;
        m_page = 1'b0; m_page_next = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    endtask

    // advance one clock; compute the outputs expected after this edge
    task automatic tick_model();
        int d;
        @(posedge clk);
        n++;
        d       = ((n - 1) / SD) % 8;
        exp_an  = ~(8'h01 << d);
        exp_seg = ref_glyph(d);
        exp_dp  = (!m_page && d == 1) ? 1'b0 : 1'b1;
        if (n % FRAME == 0) begin
            m_sign = sign; m_int = int_val_6; m_frac = frac_val_6;
            m_page = m_page_next;
        end
        if (s2 && !s3) m_page_next = !m_page_next;
        s3 = s2; s2 = s1; s1 = page_btn;
        exp_page = m_page;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({seg, dp, an, page} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got seg=%h dp=%b an=%h page=%b want seg=7f dp=1 an=ff page=0",
                         seg, dp, an, page);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick_model();
            checks++;
            if ({seg, dp, an, page} !== {exp_seg, exp_dp, exp_an, exp_page} ||
                (n == 1 && an !== 8'hFE)) begin
                errors++;
                $display("FAIL reset_scan n=%0d: got seg=%b dp=%b an=%h page=%b want seg=%b dp=%b an=%h page=%b",
                         n, seg, dp, an, page, exp_seg, exp_dp, exp_an, exp_page);
            end
        end
    endtask

    task automatic test_patterns();
        logic [3:0]  ts [2];
        logic [23:0] ti [2];
        logic [23:0] tf [2];
        ts[0] = 4'h0; ti[0] = 24'h000012; tf[0] = 24'h500000;
        ts[1] = 4'h1; ti[1] = 24'h0000A3; tf[1] = 24'h123456;
        for (int p = 0; p < 2; p++) begin
            sign = ts[p]; int_val_6 = ti[p]; frac_val_6 = tf[p];
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick_model();
                checks++;
                if ({seg, dp, an, page} !== {exp_seg, exp_dp, exp_an, exp_page}) begin
                    errors++;
                    $display("FAIL pattern%0d n=%0d: got seg=%b dp=%b an=%h want seg=%b dp=%b an=%h",
                             p, n, seg, dp, an, exp_seg, exp_dp, exp_an);
                end
            end
        end
    endtask

    task automatic test_random_midframe();
        int len;
        for (int it = 0; it < 10; it++) begin
            sign       = 4'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 15));
            int_val_6  = 24'($urandom) >> (4 * $urandom_range(0, 5));
            frac_val_6 = 24'($urandom);
            len = $urandom_range(5, 45);
            for (int i = 0; i < len; i++) begin
                tick_model();
                checks++;
                if ({seg, dp, an, page} !== {exp_seg, exp_dp, exp_an, exp_page}) begin
                    errors++;
                    $display("FAIL random it=%0d n=%0d: got seg=%b dp=%b an=%h want seg=%b dp=%b an=%h",
                             it, n, seg, dp, an, exp_seg, exp_dp, exp_an);
                end
            end
        end
    endtask

    task automatic run_checked(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            tick_model();
            checks++;
            if ({seg, dp, an, page} !== {exp_seg, exp_dp, exp_an, exp_page}) begin
                errors++;
                $display("FAIL %s n=%0d: got seg=%b dp=%b an=%h page=%b want seg=%b dp=%b an=%h page=%b",
                         tag, n, seg, dp, an, page, exp_seg, exp_dp, exp_an, exp_page);
            end
        end
    endtask

    task automatic test_page();
        sign = 4'h9; int_val_6 = 24'h000305; frac_val_6 = 24'h987654;
        while (n % FRAME != 8) tick_model();
        page_btn = 1'b1; run_checked(2, "page_single");
        page_btn = 1'b0; run_checked(3 * FRAME, "page_single");
        checks++;
        if (page !== 1'b1) begin
            errors++; $display("FAIL page_single_final: got page=%b want 1", page);
        end
        // two presses within one frame
        while (n % FRAME != 1) tick_model();
        page_btn = 1'b1; run_checked(2, "page_double");
        page_btn = 1'b0; run_checked(2, "page_double");
        page_btn = 1'b1; run_checked(2, "page_double");
        page_btn = 1'b0; run_checked(3 * FRAME, "page_double");
        checks++;
        if (page !== 1'b1) begin
            errors++; $display("FAIL page_double_final: got page=%b want 1", page);
        end
        // toggle lands exactly on a frame boundary: applied one frame later
        while (n % FRAME != FRAME - 3) tick_model();
        page_btn = 1'b1;
        run_checked(3, "page_boundary");
        page_btn = 1'b0;
        checks++;
        if (page !== 1'b1) begin
            errors++; $display("FAIL page_boundary_hold: got page=%b want 1", page);
        end
        run_checked(FRAME, "page_boundary");
        checks++;
        if (page !== 1'b0) begin
            errors++; $display("FAIL page_boundary_apply: got page=%b want 0", page);
        end
    endtask

    task automatic test_reset_midframe();
        page_btn = 1'b1; run_checked(2, "rst_mid_setup");
        page_btn = 1'b0; run_checked(2 * FRAME, "rst_mid_setup");
        while (n % FRAME != 13) tick_model();
        checks++;
        if (page !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got page=%b want 1", page);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({seg, dp, an, page} !== {7'h7F, 1'b1, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async: got seg=%h dp=%b an=%h page=%b want seg=7f dp=1 an=ff page=0",
                     seg, dp, an, page);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run_checked(FRAME + 8, "rst_mid_restart");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random_midframe();
        test_page();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decimal_display.md
# decimal_display

Display back-end for the decimal entry path. Takes the sign nibble, the 6-digit BCD integer part and the 6-digit BCD fractional part produced by the entry block. Drives an 8-digit, time-multiplexed, common-anode 7-segment display. Provides two display pages, integer and fraction, selected by a push-button, and tear-free frame snapshots.

## Interface
- SCAN_DIV, 100000: clock cycles each digit is driven; minimum 2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sign  in  4  sign nibble; 4'h0 = positive, any other value = negative.
- int_val_6  in  24  integer part, 6 BCD nibbles, [23:20] most significant.
- frac_val_6  in  24  fractional part, 6 BCD nibbles, [23:20] first after the point.
- page_btn  in  1  page toggle, asynchronous level (debounced externally).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  digit enables, active-low; an[0] is the rightmost digit.
- page  out  1  current page; 0 = INT, 1 = FRAC.

## Operation
- Scan divider counts 0..SCAN_DIV-1. On its terminal count (tick), the digit index advances 0→1→…→7→0.
- Frame boundary: a tick while index==7.
  - sign, int_val_6 and frac_val_6 are captured into a snapshot register.
  - page is loaded from page_next.
  - All glyphs come from the snapshot only.
- page_btn passes through a 2-FF synchronizer and a rising-edge detector. Each edge toggles page_next.
  - Two presses inside one frame leave the page unchanged.
- Glyphs:
  - 0-9 use the standard patterns ('0'=7'b1000000, '1'=7'b1111001, …, '8'=7'b0000000).
  - A non-BCD nibble (A-F) shows 'E' (7'b0000110).
  - Minus sign is 7'b0111111. Blank is 7'b1111111.
- INT page layout:
  - an[7]: minus if the snapshot sign is nonzero, else blank.
  - an[6]..an[1]: integer nibbles [23:20]..[3:0].
  - an[0]: fraction nibble [23:20].
  - dp is low only while an[1] is active.
- FRAC page layout:
  - an[7], an[6]: blank.
  - an[5]..an[0]: fraction nibbles [23:20]..[3:0].
  - dp is always high.
- Exactly one an bit is low at any time after the first post-reset cycle.

## Timing
- Reset values:
  - seg=7'h7F, dp=1, an=8'hFF, page=0.
  - page_next=0, divider=0, index=0, snapshot=0.
- seg, dp and an are registered: one cycle of latency from an index change to the outputs.
- First cycle after reset release: an=8'hFE, showing the snapshot as it stands (zeros, i.e. '0' on the INT page).
- Each digit is held for exactly SCAN_DIV cycles. One frame is 8·SCAN_DIV cycles.
- Input changes are visible from the first digit of the next frame, never mid-frame.
- A page_btn rising edge is seen 3 cycles later in page_next. It is applied at the next frame boundary.
- A button edge on the same cycle as a frame boundary is applied at the following boundary.
- Reset asserted mid-frame returns all state to the reset values immediately (asynchronously).

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - On the INT page, integer digits an[6]..an[2] that are zero and to the left of the first nonzero integer digit show blank.
  - an[1] is always shown.
  - Non-BCD nibbles count as nonzero.
  - The sign stays at an[7].
- Not defined: every integer digit is shown, including leading zeros.
- The FRAC page is never blanked in either configuration.

## Test plan
- Reset, SCAN_DIV=4, hold rst 3 cycles, then release -> seg=7'h7F, an=8'hFF during reset; an=8'hFE on the first cycle after release; an walks FE,FD,…,7F every 4 cycles; frame period is 32 cycles.
- Inputs sign=0, int=24'h000012, frac=24'h500000 -> an[1] shows '2' with dp=0; an[0] shows '5'; an[7] is blank. Without LEADING_ZERO_BLANK_EN, an[6..3] show '0'. With it, those digits are blank and an[2] shows '1'.
- sign=4'h1, int=24'h0000A3 -> an[7]=7'b0111111 (minus); an[2]=7'b0000110 ('E').
- Change int_val_6 in the middle of a frame -> the remaining digits of that frame show the old value; the new value appears from the next frame's an[0].
- One page_btn pulse -> page=1 at the next frame boundary; FRAC layout shown, dp never low. Two pulses within one frame -> page stays 0.
- Assert rst mid-frame while page=1 -> page=0, an=8'hFF immediately; the scan restarts at digit 0 after release.
